// File: rtl/alu_program_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_program_sequencer_if
//
// Host-facing bus of the ALU program sequencer: a command channel used to
// load (opcode, operand) entries, and a result channel returning one captured
// ALU result per executed entry.
//
// Signals:
//   cmd_valid / cmd_ready      command handshake (host -> sequencer)
//   cmd_opcode  [3:0]          ALU opcode of the command
//   cmd_operand [DATA_W-1:0]   operand of the command
//   res_valid / res_ready      result handshake (sequencer -> host)
//   res_data    [RES_W-1:0]    captured ALU output
//   res_error   [1:0]          captured ALU error
//   res_index   [IDX_W-1:0]    program index the result belongs to
//
// Modports: master = host side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface alu_program_sequencer_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int RES_W  = 64
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_opcode;
  logic [DATA_W-1:0] cmd_operand;

  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic [1:0]        res_error;
  logic [IDX_W-1:0]  res_index;

  modport master (
    output cmd_valid, cmd_opcode, cmd_operand, res_ready,
    input  cmd_ready, res_valid, res_data, res_error, res_index
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_operand, res_ready,
    output cmd_ready, res_valid, res_data, res_error, res_index
  );
endinterface

// File: rtl/alu_program_sequencer.sv
// ---------------------------------------------------------------------------
// alu_program_sequencer
//
// Initiator-side driver for the accumulator ALU breadboard. A host loads a
// short program of (opcode, operand) commands; on start the entries are
// issued one per ISSUE cycle on the ALU lines, and the ALU output/error seen
// on that cycle's closing edge is returned to the host over the result
// channel together with the entry index.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   bus            alu_program_sequencer_if.slave (command + result channels)
//   start          begin executing the loaded program (IDLE only)
//   busy           high in every state except IDLE
//   alu_opcode     opcode to the ALU (NOOP 0000 outside ISSUE)
//   alu_input      operand to the ALU (0 outside ISSUE)
//   alu_output     ALU output1
//   alu_error      ALU error
//   done           one-cycle pulse at end of program
//   aborted        program ended early; meaningful while done is high
//
// Optional feature (macro SEQ_HALT_ON_ERR_EN): when defined, a result with a
// non-zero error ends the program at its handshake and flags aborted.
// ---------------------------------------------------------------------------
module alu_program_sequencer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int RES_W  = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  alu_program_sequencer_if.slave  bus,
  input  logic                    start,
  output logic                    busy,
  output logic [3:0]              alu_opcode,
  output logic [DATA_W-1:0]       alu_input,
  input  logic [RES_W-1:0]        alu_output,
  input  logic [1:0]              alu_error,
  output logic                    done,
  output logic                    aborted
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, REPORT, DONE} state_t;

  state_t state, state_next;

  logic [3:0]        prog_opcode  [DEPTH];
  logic [DATA_W-1:0] prog_operand [DEPTH];

  logic [IDX_W:0]    count;
  logic [IDX_W-1:0]  ptr;
  logic [RES_W-1:0]  res_data_q;
  logic [1:0]        res_error_q;
  logic [IDX_W-1:0]  res_index_q;
  logic              abort_q;

  logic              cmd_accept;
  logic [IDX_W:0]    count_m1;
  logic              last_entry;
  logic              halt;
  logic              finish;

  // Ready is gated by reset directly so it reads 0 while reset is held,
  // even though the registered state already looks like an empty IDLE.
  assign bus.cmd_ready = reset && (state == IDLE) && (count != FULL);
  assign cmd_accept    = bus.cmd_valid && bus.cmd_ready;

  assign count_m1   = count - 1'b1;
  assign last_entry = ({1'b0, ptr} == count_m1);

`ifdef SEQ_HALT_ON_ERR_EN
  assign halt = (res_error_q != 2'b00);
`else
  assign halt = 1'b0;
`endif

  assign finish = last_entry || halt;

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign aborted       = done && abort_q;
  assign bus.res_valid = (state == REPORT);
  assign bus.res_data  = res_data_q;
  assign bus.res_error = res_error_q;
  assign bus.res_index = res_index_q;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and ALU drive. The ALU only sees a real command during ISSUE;
  // every other state presents NOOP so the accumulator holds.
  always_comb begin
    state_next = state;
    alu_opcode = 4'b0000;
    alu_input  = '0;
    case (state)
      IDLE: begin
        // A command accepted in the same cycle as start counts as loaded.
        if (start && ((count != '0) || cmd_accept)) state_next = ISSUE;
      end
      ISSUE: begin
        alu_opcode = prog_opcode[ptr];
        alu_input  = prog_operand[ptr];
        state_next = REPORT;
      end
      REPORT: begin
        if (bus.res_ready) state_next = finish ? DONE : ISSUE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Program storage. Entries are never cleared; count alone defines validity.
  always_ff @(posedge clock) begin
    if (cmd_accept) begin
      prog_opcode[count[IDX_W-1:0]]  <= bus.cmd_opcode;
      prog_operand[count[IDX_W-1:0]] <= bus.cmd_operand;
    end
  end

  // Control counters and result capture. The result is sampled on the edge
  // that closes ISSUE, which is the edge the ALU accumulator updates on.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      ptr         <= '0;
      res_data_q  <= '0;
      res_error_q <= 2'b00;
      res_index_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_accept) count <= count + 1'b1;
          ptr <= '0;
        end
        ISSUE: begin
          res_data_q  <= alu_output;
          res_error_q <= alu_error;
          res_index_q <= ptr;
        end
        REPORT: begin
          if (bus.res_ready) begin
            if (finish) abort_q <= halt;
            else        ptr     <= ptr + 1'b1;
          end
        end
        DONE: begin
          count <= '0;
          ptr   <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/alu_program_sequencer.md
Name: alu_program_sequencer

Overview:
- Initiator-side driver for the accumulator ALU breadboard.
- Buffers a short program of (opcode, operand) commands loaded from a host. On start, it issues the commands one at a time on the ALU's opcode/input lines.
- For each command it captures the ALU's 64-bit output and 2-bit error. Each captured result goes back to the host over a valid/ready result port.
- It replaces hand-written testbench stimulus with a synthesizable sequencer.

Parameters:
- DEPTH, 8, number of program entries (power of 2, ≥2).
- DATA_W, 32, operand width (ALU input width).
- RES_W, 64, ALU result width.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  host command valid.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_opcode  input  4  ALU opcode of command.
- cmd_operand  input  DATA_W  operand of command.
- start  input  1  begin executing the loaded program.
- busy  output  1  high in every state except IDLE.
- alu_opcode  output  4  to ALU opcode.
- alu_input  output  DATA_W  to ALU input1.
- alu_output  input  RES_W  from ALU output1.
- alu_error  input  2  from ALU error.
- res_valid  output  1  result available.
- res_ready  input  1  host accepts result.
- res_data  output  RES_W  captured ALU output.
- res_error  output  2  captured ALU error.
- res_index  output  log2(DEPTH)  program index of the result.
- done  output  1  one-cycle pulse at end of program.
- aborted  output  1  program ended early (see Optional Feature); valid with done.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; program buffer cleared (count=0, ptr=0).
  - alu_opcode=4'b0000 and alu_input=0 (NOOP, so the ALU accumulator holds).
  - res_valid, res_data, res_error, res_index, done, aborted = 0; busy=0.
  - cmd_ready=0 while reset is asserted, 1 from the first cycle after release.
  - The sequencer never clears the ALU accumulator itself; a program must issue opcode 1101 for that.
- Reset mid-program: the same values apply immediately, the program is discarded, and no done pulse is produced.
- Load (IDLE only):
  - cmd_ready = (count < DEPTH).
  - On cmd_valid & cmd_ready the entry is written at index count, and count increments.
  - When count == DEPTH, cmd_ready drops and further cmd_valid is ignored.
  - In all other states cmd_ready = 0.
- Start:
  - start in IDLE with count > 0: move to ISSUE with ptr=0.
  - start with count == 0: ignored.
  - cmd_valid and start in the same cycle: the command is accepted first and is part of the program.
  - start outside IDLE: ignored.
- States: IDLE, ISSUE, REPORT, DONE.
- ISSUE (exactly 1 cycle):
  - Drive alu_opcode/alu_input from entry[ptr].
  - On the closing edge, register alu_output into res_data, alu_error into res_error, and ptr into res_index.
  - This is the same edge on which the ALU accumulator updates.
  - Go to REPORT.
- REPORT:
  - ALU lines are driven to NOOP (0000, 0). Outputs are NOOP in every state except ISSUE.
  - res_valid=1; res_data, res_error and res_index are held stable until res_valid & res_ready.
  - On the handshake: if ptr == count-1, go to DONE; otherwise ptr++ and go to ISSUE.
- DONE (1 cycle):
  - done=1; aborted is set as decided (see Optional Feature).
  - Buffer is cleared (count=0); go to IDLE.
- Latency:
  - Minimum 2 cycles per command (ISSUE + REPORT with res_ready held high).
  - res_valid rises 1 cycle after the ISSUE cycle.
  - Program end: done asserts the cycle after the last handshake.
- Forwarding: opcodes are passed unchanged, including 1110/1111 (unknown). Whatever the ALU returns is reported.
- Operand width: operands are passed through at DATA_W. No sign handling in this block.

Optional Feature:
- Macro: SEQ_HALT_ON_ERR_EN.
- Defined: at the REPORT handshake, if res_error != 2'b00, go to DONE regardless of ptr; aborted=1 during the done pulse.
- Not defined: errors are reported only, the program always runs to completion, and aborted stays 0.

Test Plan:
- Reset/load:
  - Hold reset=0, then release.
  - Check cmd_ready=1, alu_opcode=0000, busy=0.
  - Push 8 commands: cmd_ready=0 after the 8th; a 9th cmd_valid is not accepted.
- Circumference program against the breadboard ALU, res_ready tied high:
  - Program: (1101,0), (0001,2), (0011,5), (0011,314), (0100,100).
  - Expected res_data: 0, 2, 10, 3140, 31.
  - Expected res_index: 0..4.
  - done pulses once, 1 cycle after the 5th handshake.
- Backpressure:
  - Hold res_ready=0 for 5 cycles after the first res_valid.
  - res_data/res_index stay stable; alu_opcode stays 0000.
  - The ALU accumulator stays unchanged (a following ADD 1 yields previous+1).
- Start edge cases:
  - start with an empty buffer: busy stays 0.
  - cmd_valid plus start in the same cycle with (0001,7) as the only entry: a single result of 7 (accumulator previously 0), then done.
- Error/halt, using an ALU stub that returns alu_error=2'b01 on index 1 of a 4-entry program:
  - With SEQ_HALT_ON_ERR_EN: 2 results, done with aborted=1.
  - Without it: 4 results, res_error=01 on index 1, aborted=0.
- Reset mid-program:
  - Assert reset=0 during the REPORT of index 2.
  - res_valid=0 immediately; no done pulse.
  - After release: busy=0 and count=0 (cmd_ready=1; a new 1-entry program returns index 0).
